pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program counter and fetch control for the instruction memory.
//             Holds the 64-bit PC, picks the next PC from JALR, branch or
//             sequential sources, honours stalls, and halts at end of
//             program or on a misaligned target.
//  Ports    :
//    clk                 system clock, rising edge
//    rst_n               asynchronous active-low reset
//    stall_i             hold PC, state and counter this cycle
//    branch_taken_i      conditional branch resolved taken
//    branch_offset_i     signed byte offset added to the PC
//    jump_reg_i          JALR request (wins over branch_taken_i)
//    jump_base_i         rs1 value for JALR
//    jump_offset_i       signed immediate for JALR
//    pc_o                current PC, instruction memory address
//    pc_plus4_o          pc_o + 4, link value
//    fetch_valid_o       instruction at pc_o consumed this cycle
//    halted_o            unit is in HALT
//    misaligned_fault_o  sticky misaligned-target flag
//    fetch_count_o       saturating count of consumed fetches
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          NUM_INSTR = 13,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [63:0]      branch_offset_i,
    input  logic             jump_reg_i,
    input  logic [63:0]      jump_base_i,
    input  logic [63:0]      jump_offset_i,
    output logic [63:0]      pc_o,
    output logic [63:0]      pc_plus4_o,
    output logic             fetch_valid_o,
    output logic             halted_o,
    output logic             misaligned_fault_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    // First address past the program image.
    localparam logic [63:0]      C_END_ADDR = RESET_PC + (64'(NUM_INSTR) << 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic               fault_q, fault_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [63:0]        w_pc_plus4;
    logic [63:0]        w_branch_tgt;
    logic [63:0]        w_jalr_tgt;
    logic [63:0]        w_target;
    logic               w_misaligned;
    logic               w_at_end;

    assign w_pc_plus4   = pc_q + 64'd4;
    assign w_branch_tgt = pc_q + branch_offset_i;
    // JALR always clears bit 0 of the sum before the alignment check.
    assign w_jalr_tgt   = (jump_base_i + jump_offset_i) & ~64'h1;

    always_comb begin
        w_target = w_pc_plus4;
        if (jump_reg_i) begin
            w_target = w_jalr_tgt;
        end else if (branch_taken_i) begin
            w_target = w_branch_tgt;
        end
    end

    assign w_misaligned = |w_target[1:0];
    assign w_at_end     = (w_target >= C_END_ADDR);

    assign fetch_valid_o = (state_q == ST_RUN) && !stall_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (!(&count_q)) begin
                        count_d = count_q + C_CNT_ONE;
                    end
                    if (w_misaligned) begin
                        // PC keeps the address of the faulting instruction.
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        // End-of-program still loads the target so the PC
                        // rests on the out-of-range address.
                        pc_d = w_target;
                        if (w_at_end) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_plus4_o         = w_pc_plus4;
    assign halted_o           = halted_q;
    assign misaligned_fault_o = fault_q;
    assign fetch_count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Scoreboard bench for pc_fetch_unit: directed scenarios plus
//             randomized next-PC traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam int          NUM_INSTR = 13;
    localparam int          CNT_W     = 32;
    localparam logic [63:0] END_ADDR  = RESET_PC + 64'd52;

    localparam int PH_BOOT = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_HALT = 2;

    logic             clk;
    logic             rst_n;
    logic             stall_i;
    logic             branch_taken_i;
    logic [63:0]      branch_offset_i;
    logic             jump_reg_i;
    logic [63:0]      jump_base_i;
    logic [63:0]      jump_offset_i;
    logic [63:0]      pc_o;
    logic [63:0]      pc_plus4_o;
    logic             fetch_valid_o;
    logic             halted_o;
    logic             misaligned_fault_o;
    logic [CNT_W-1:0] fetch_count_o;

    pc_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NUM_INSTR (NUM_INSTR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall_i            (stall_i),
        .branch_taken_i     (branch_taken_i),
        .branch_offset_i    (branch_offset_i),
        .jump_reg_i         (jump_reg_i),
        .jump_base_i        (jump_base_i),
        .jump_offset_i      (jump_offset_i),
        .pc_o               (pc_o),
        .pc_plus4_o         (pc_plus4_o),
        .fetch_valid_o      (fetch_valid_o),
        .halted_o           (halted_o),
        .misaligned_fault_o (misaligned_fault_o),
        .fetch_count_o      (fetch_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic        fv;
        logic        halted;
        logic        fault;
        logic [63:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_phase;
    logic [63:0] m_pc;
    logic        m_fault;
    longint      m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_BOOT;
        m_pc    = RESET_PC;
        m_fault = 1'b0;
        m_count = 0;
    endtask

    // One clock edge of the architectural rules.
    task automatic model_step(input logic s, input logic b, input logic [63:0] bo,
                              input logic j, input logic [63:0] jb, input logic [63:0] jo);
        logic [63:0] tgt;
        if (m_phase == PH_BOOT) begin
            m_phase = PH_RUN;
        end else if (m_phase == PH_RUN && !s) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (j)      tgt = (jb + jo) & ~64'h1;
            else if (b) tgt = m_pc + bo;
            else        tgt = m_pc + 64'd4;
            if (tgt % 4 != 0) begin
                m_fault = 1'b1;
                m_phase = PH_HALT;
            end else begin
                m_pc = tgt;
                if (tgt >= END_ADDR) m_phase = PH_HALT;
            end
        end
    endtask

    // Called at posedge+1: drive inputs, record expectation for this cycle,
    // then let one edge pass and advance the model.
    task automatic cycle(input logic s, input logic b, input logic [63:0] bo,
                         input logic j, input logic [63:0] jb, input logic [63:0] jo);
        exp_t e;
        stall_i         = s;
        branch_taken_i  = b;
        branch_offset_i = bo;
        jump_reg_i      = j;
        jump_base_i     = jb;
        jump_offset_i   = jo;
        e.pc     = m_pc;
        e.pc4    = m_pc + 64'd4;
        e.fv     = (m_phase == PH_RUN) && !s;
        e.halted = (m_phase == PH_HALT);
        e.fault  = m_fault;
        e.count  = 64'(m_count);
        exp_q.push_back(e);
        @(posedge clk);
        model_step(s, b, bo, j, jb, jo);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic run_to(input logic [63:0] tgt);
        int n;
        n = 0;
        while (!(m_phase == PH_RUN && m_pc == tgt) && n < 40) begin
            idle();
            n++;
        end
        if (!(m_phase == PH_RUN && m_pc == tgt)) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: could not reach pc %h (model pc %h)", tgt, m_pc);
        end
    endtask

    // Assert reset mid-cycle (posedge+3) and check outputs before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pc",     pc_o,                 RESET_PC);
        chk("rst_fv",     64'(fetch_valid_o),   64'h0);
        chk("rst_halted", 64'(halted_o),        64'h0);
        chk("rst_fault",  64'(misaligned_fault_o), 64'h0);
        chk("rst_count",  64'(fetch_count_o),   64'h0);
        model_reset();
        stall_i = 1'b0; branch_taken_i = 1'b0; jump_reg_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        logic        s, b, j;
        logic [63:0] bo, jb, jo;
        longint      o;
        s = ($urandom_range(0, 3) == 0);
        b = ($urandom_range(0, 2) == 0);
        o = longint'($urandom_range(0, 16)) * 4 - 32;
        if ($urandom_range(0, 7) == 0) o = o + longint'($urandom_range(1, 3));
        bo = o;
        j  = ($urandom_range(0, 6) == 0);
        jb = 64'($urandom_range(0, 60));
        if ($urandom_range(0, 9) == 0) jb = 64'hFFFF_FFFF_FFFF_FFF0;
        o  = longint'($urandom_range(0, 48)) - 8;
        jo = o;
        cycle(s, b, bo, j, jb, jo);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc",          pc_o,                      e.pc);
            chk("pc_plus4",    pc_plus4_o,                e.pc4);
            chk("fetch_valid", 64'(fetch_valid_o),        64'(e.fv));
            chk("halted",      64'(halted_o),             64'(e.halted));
            chk("fault",       64'(misaligned_fault_o),   64'(e.fault));
            chk("fetch_count", 64'(fetch_count_o),        e.count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; branch_taken_i = 1'b0; branch_offset_i = '0;
        jump_reg_i = 1'b0; jump_base_i = '0; jump_offset_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Straight-line program to end-of-program halt, count holds at 13
        repeat (18) idle();

        // Taken branches backwards and forwards
        do_reset();
        run_to(64'h08);
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 64'h0);
        run_to(64'h08);
        cycle(1'b0, 1'b1, 64'h10, 1'b0, 64'h0, 64'h0);
        repeat (3) idle();

        // JALR with bit-0 clear wins over a simultaneous branch
        do_reset();
        run_to(64'h10);
        cycle(1'b0, 1'b1, 64'h4, 1'b1, 64'h21, 64'h3);
        repeat (2) idle();

        // Stall for three cycles with a branch present, then resume
        do_reset();
        run_to(64'h0C);
        repeat (3) cycle(1'b1, 1'b1, 64'h20, 1'b0, 64'h0, 64'h0);
        repeat (2) idle();

        // Misaligned JALR target, then stimulus has no effect
        do_reset();
        run_to(64'h08);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'h10, 64'h6);
        repeat (6) rand_cycle();

        // Asynchronous reset while running
        do_reset();
        run_to(64'h1C);
        chk("pre_rst_pc", pc_o, 64'h1C);
        do_reset();
        repeat (4) idle();

        // Randomized traffic
        for (int r = 0; r < 20; r++) begin
            do_reset();
            repeat (25) rand_cycle();
        end

        @(negedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
